// File: rtl/decode_stage.sv
// RV32I/Zicsr decode stage with a two-entry (head + skid) elastic output buffer.
// Optional CSR support is enabled by defining DECODE_ZICSR_EN.
module decode_stage #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_PC_TAG = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [6:0]      o_opcode,
    output logic [4:0]      o_rd_addr,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic [XLEN-1:0] o_imm,
    output logic [XLEN-1:0] o_pc,
    output logic            o_illegal,
    output logic [11:0]     o_csr_addr,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic [4:0]      o_rf_rs1_addr,
    output logic [4:0]      o_rf_rs2_addr
);

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
        logic [11:0]     csr;
    } dec_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_valid;
    dec_t               r_head;
    dec_t               r_skid;

    dec_t               w_dec;
    logic signed [31:0] w_imm32;
    logic               w_zimm;
    logic               w_illegal;
    logic [11:0]        w_csr;
    logic               w_accept;
    logic               w_pop;

    always_comb begin
        w_imm32   = '0;
        w_zimm    = 1'b0;
        w_csr     = '0;
        w_illegal = (i_inst[1:0] != 2'b11);
        case (i_inst[6:0])
            7'h03, 7'h13, 7'h67: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            7'h23: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            7'h63: w_imm32 = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            7'h37, 7'h17: w_imm32 = {i_inst[31:12], 12'b0};
            7'h6F: w_imm32 = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            7'h0F: w_imm32 = '0;
            7'h33: begin
                if (i_inst[31:25] != 7'h00 && i_inst[31:25] != 7'h20)
                    w_illegal = 1'b1;
                if (i_inst[31:25] == 7'h20 && i_inst[14:12] != 3'b000 && i_inst[14:12] != 3'b101)
                    w_illegal = 1'b1;
            end
            7'h73: begin
`ifdef DECODE_ZICSR_EN
                w_csr  = i_inst[31:20];
                w_zimm = i_inst[14] && (i_inst[13:12] != 2'b00);
                if (i_inst[14:12] == 3'b100)
                    w_illegal = 1'b1;
`else
                if (i_inst[14:12] != 3'b000)
                    w_illegal = 1'b1;
`endif
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_dec         = '0;
        w_dec.opcode  = i_inst[6:0];
        w_dec.rd      = i_inst[11:7];
        w_dec.funct3  = i_inst[14:12];
        w_dec.funct7  = i_inst[31:25];
        w_dec.rs1     = i_inst[19:15];
        w_dec.rs2     = i_inst[24:20];
        w_dec.pc      = i_pc;
        w_dec.illegal = w_illegal;
        w_dec.csr     = w_csr;
        if (w_zimm)
            w_dec.imm = XLEN'(i_inst[19:15]);
        else
            w_dec.imm = XLEN'(w_imm32);
    end

    assign w_accept = i_valid && r_ready;
    assign w_pop    = r_valid && i_ready;

    // Head always holds the oldest entry; skid only fills from ONE without a pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_EMPTY;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_head      <= '0;
            r_head.pc   <= RESET_PC_TAG;
            r_skid      <= '0;
        end else if (i_flush) begin
            r_state     <= ST_EMPTY;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_head.pc   <= RESET_PC_TAG;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head  <= w_dec;
                        r_valid <= 1'b1;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        r_head <= w_dec;
                    end else if (w_accept) begin
                        r_skid  <= w_dec;
                        r_ready <= 1'b0;
                        r_state <= ST_FULL;
                    end else if (w_pop) begin
                        r_valid   <= 1'b0;
                        r_head.pc <= RESET_PC_TAG;
                        r_state   <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_skid;
                        r_ready <= 1'b1;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready       = r_ready;
    assign o_valid       = r_valid;
    assign o_opcode      = r_head.opcode;
    assign o_rd_addr     = r_head.rd;
    assign o_funct3      = r_head.funct3;
    assign o_funct7      = r_head.funct7;
    assign o_imm         = r_head.imm;
    assign o_pc          = r_head.pc;
    assign o_illegal     = r_head.illegal;
    assign o_csr_addr    = r_head.csr;
    assign o_rs1_addr    = r_head.rs1;
    assign o_rs2_addr    = r_head.rs2;
    assign o_rf_rs1_addr = i_inst[19:15];
    assign o_rf_rs2_addr = i_inst[24:20];

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage; expectations come from a queue model and
// an arithmetic decode reference. CSR expectations follow DECODE_ZICSR_EN.
module tb_decode_stage;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] TAG  = 32'hDEAD_0F00;
    localparam logic [6:0]  OPS [11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                                         7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73};

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
        logic [11:0] csr;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_inst = '0;
    logic [31:0] i_pc = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [6:0]  o_opcode;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [31:0] o_imm;
    logic [31:0] o_pc;
    logic        o_illegal;
    logic [11:0] o_csr_addr;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [4:0]  o_rf_rs1_addr;
    logic [4:0]  o_rf_rs2_addr;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q[$];

    decode_stage #(.XLEN(XLEN), .RESET_PC_TAG(TAG)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_opcode(o_opcode), .o_rd_addr(o_rd_addr),
        .o_funct3(o_funct3), .o_funct7(o_funct7), .o_imm(o_imm), .o_pc(o_pc),
        .o_illegal(o_illegal), .o_csr_addr(o_csr_addr), .o_rs1_addr(o_rs1_addr),
        .o_rs2_addr(o_rs2_addr), .o_rf_rs1_addr(o_rf_rs1_addr),
        .o_rf_rs2_addr(o_rf_rs2_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model_dec(input logic [31:0] inst, input logic [31:0] pc);
        exp_t       e;
        int         s;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         known;
        s  = inst;
        op = inst[6:0];
        f3 = inst[14:12];
        f7 = inst[31:25];
        e  = '0;
        e.opcode = op;  e.rd = inst[11:7];  e.funct3 = f3;  e.funct7 = f7;
        e.rs1 = inst[19:15];  e.rs2 = inst[24:20];  e.pc = pc;
        known = 1'b0;
        for (int i = 0; i < 11; i++)
            if (OPS[i] == op) known = 1'b1;
        e.illegal = (inst[1:0] != 2'b11) || !known;
        case (op)
            7'h03, 7'h13, 7'h67: e.imm = s >>> 20;
            7'h23: e.imm = ((s >>> 25) <<< 5) | int'(inst[11:7]);
            7'h63: e.imm = ((s >>> 31) <<< 12) | (int'(inst[7]) << 11)
                         | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
            7'h37, 7'h17: e.imm = inst & 32'hFFFF_F000;
            7'h6F: e.imm = ((s >>> 31) <<< 20) | (int'(inst[19:12]) << 12)
                         | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
            7'h33: begin
                if (f7 != 7'h00 && f7 != 7'h20) e.illegal = 1'b1;
                if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) e.illegal = 1'b1;
            end
            7'h73: begin
`ifdef DECODE_ZICSR_EN
                e.csr = inst[31:20];
                if (f3 == 3'd4) e.illegal = 1'b1;
                if (f3 >= 3'd5) e.imm = 32'(inst[19:15]);
`else
                if (f3 != 3'd0) e.illegal = 1'b1;
`endif
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.opcode = o_opcode;  o.rd = o_rd_addr;  o.funct3 = o_funct3;  o.funct7 = o_funct7;
        o.rs1 = o_rs1_addr;  o.rs2 = o_rs2_addr;  o.imm = o_imm;  o.pc = o_pc;
        o.illegal = o_illegal;  o.csr = o_csr_addr;
        return o;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int unsigned k;
        w = $urandom;
        k = $urandom_range(0, 13);
        if (k < 11) w[6:0] = OPS[k];
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        exp_t r;
        r    = '0;
        r.pc = TAG;
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid);
        end
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready);
        end
        n_checks++;
        if (observed() !== r) begin
            n_fail++; $display("FAIL reset_fields: got %h expected %h", observed(), r);
        end
        i_inst = 32'h00A5_8000;
        #1;
        n_checks++;
        if (o_rf_rs1_addr !== 5'd11 || o_rf_rs2_addr !== 5'd10) begin
            n_fail++; $display("FAIL rf_addr_comb: got %0d/%0d expected 11/10", o_rf_rs1_addr, o_rf_rs2_addr);
        end
    endtask

    task automatic test_basic();
        i_inst = 32'hFFF0_0093; i_pc = 32'h100; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1 || o_opcode !== 7'h13 || o_rd_addr !== 5'd1 || o_imm !== 32'hFFFF_FFFF
            || o_pc !== 32'h100 || o_illegal !== 1'b0) begin
            n_fail++; $display("FAIL basic_addi: got v=%b op=%h rd=%0d imm=%h pc=%h ill=%b expected v=1 op=13 rd=1 imm=ffffffff pc=100 ill=0",
                               o_valid, o_opcode, o_rd_addr, o_imm, o_pc, o_illegal);
        end
        n_checks++;
        if (observed() !== model_dec(32'hFFF0_0093, 32'h100)) begin
            n_fail++; $display("FAIL basic_model: got %h expected %h", observed(), model_dec(32'hFFF0_0093, 32'h100));
        end
        drain();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1; i_valid = 1'b1;
        i_inst = 32'h0020_A423; i_pc = 32'h200;
        tick();
        i_inst = 32'hFE00_0EE3; i_pc = 32'h204;
        n_checks++;
        if (o_valid !== 1'b1 || o_imm !== 32'h8 || o_pc !== 32'h200) begin
            n_fail++; $display("FAIL b2b_sw: got v=%b imm=%h pc=%h expected v=1 imm=8 pc=200", o_valid, o_imm, o_pc);
        end
        tick();
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1 || o_imm !== 32'hFFFF_FFFC || o_pc !== 32'h204) begin
            n_fail++; $display("FAIL b2b_beq: got v=%b imm=%h pc=%h expected v=1 imm=fffffffc pc=204", o_valid, o_imm, o_pc);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drained: got %b expected 0", o_valid);
        end
        drain();
    endtask

    task automatic test_backpressure();
        exp_t ea, eb, ec;
        ea = model_dec(32'h0000_0013, 32'h300);
        eb = model_dec(32'h0011_0113, 32'h304);
        ec = model_dec(32'h4020_81B3, 32'h308);
        i_ready = 1'b0; i_valid = 1'b1;
        i_inst = 32'h0000_0013; i_pc = 32'h300;
        tick();
        i_inst = 32'h0011_0113; i_pc = 32'h304;
        tick();
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready_drop: got %b expected 0", o_ready);
        end
        i_inst = 32'h4020_81B3; i_pc = 32'h308;
        tick();
        tick();
        n_checks++;
        if (o_ready !== 1'b0 || observed() !== ea) begin
            n_fail++; $display("FAIL bp_hold_A: got rdy=%b %h expected rdy=0 %h", o_ready, observed(), ea);
        end
        i_ready = 1'b1;
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || observed() !== eb) begin
            n_fail++; $display("FAIL bp_head_B: got v=%b %h expected v=1 %h", o_valid, observed(), eb);
        end
        tick();
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1 || observed() !== ec) begin
            n_fail++; $display("FAIL bp_head_C: got v=%b %h expected v=1 %h", o_valid, observed(), ec);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_pc !== TAG) begin
            n_fail++; $display("FAIL bp_no_dup: got v=%b pc=%h expected v=0 pc=%h", o_valid, o_pc, TAG);
        end
        drain();
    endtask

    task automatic test_flush();
        i_ready = 1'b0; i_valid = 1'b1;
        i_inst = 32'h0050_0093; i_pc = 32'h400;
        tick();
        i_inst = 32'h0060_0113; i_pc = 32'h404;
        tick();
        i_flush = 1'b1;
        i_inst = 32'h0070_0193; i_pc = 32'h408;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_pc !== TAG) begin
            n_fail++; $display("FAIL flush_empty: got v=%b rdy=%b pc=%h expected v=0 rdy=1 pc=%h", o_valid, o_ready, o_pc, TAG);
        end
        i_ready = 1'b1;
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_absent: got %b expected 0", o_valid);
        end
        drain();
    endtask

    task automatic test_csr();
        i_ready = 1'b0; i_valid = 1'b1;
        i_inst = 32'h3003_12F3; i_pc = 32'h500;
        tick();
        i_valid = 1'b0;
`ifdef DECODE_ZICSR_EN
        n_checks++;
        if (o_csr_addr !== 12'h300 || o_rs1_addr !== 5'd6 || o_illegal !== 1'b0) begin
            n_fail++; $display("FAIL csrrw: got csr=%h rs1=%0d ill=%b expected csr=300 rs1=6 ill=0", o_csr_addr, o_rs1_addr, o_illegal);
        end
`else
        n_checks++;
        if (o_illegal !== 1'b1 || o_csr_addr !== 12'h000) begin
            n_fail++; $display("FAIL csrrw: got ill=%b csr=%h expected ill=1 csr=000", o_illegal, o_csr_addr);
        end
`endif
        n_checks++;
        if (observed() !== model_dec(32'h3003_12F3, 32'h500)) begin
            n_fail++; $display("FAIL csrrw_model: got %h expected %h", observed(), model_dec(32'h3003_12F3, 32'h500));
        end
        drain();
    endtask

    task automatic test_illegal_zero();
        i_ready = 1'b0; i_valid = 1'b1;
        i_inst = 32'h0000_0000; i_pc = 32'h600;
        tick();
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1 || o_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_zero: got v=%b ill=%b expected v=1 ill=1", o_valid, o_illegal);
        end
        drain();
    endtask

    task automatic test_reset_full();
        exp_t r;
        r    = '0;
        r.pc = TAG;
        i_ready = 1'b0; i_valid = 1'b1;
        i_inst = 32'hFFF0_0093; i_pc = 32'h700;
        tick();
        i_inst = 32'h0020_A423; i_pc = 32'h704;
        tick();
        i_rst = 1'b1; i_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || observed() !== r) begin
            n_fail++; $display("FAIL reset_full: got v=%b rdy=%b %h expected v=0 rdy=1 %h", o_valid, o_ready, observed(), r);
        end
        drain();
    endtask

    task automatic test_random();
        bit acc, pop;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 40) == 0);
            i_inst  = rand_inst();
            i_pc    = $urandom & 32'hFFFF_FFFC;
            #3;
            n_checks++;
            if (o_rf_rs1_addr !== i_inst[19:15] || o_rf_rs2_addr !== i_inst[24:20]) begin
                n_fail++; $display("FAIL rnd_rf_addr cyc %0d: got %0d/%0d expected %0d/%0d", cyc,
                                   o_rf_rs1_addr, o_rf_rs2_addr, i_inst[19:15], i_inst[24:20]);
            end
            n_checks++;
            if (o_valid !== (q.size() != 0) || o_ready !== (q.size() < 2)) begin
                n_fail++; $display("FAIL rnd_handshake cyc %0d: got v=%b rdy=%b expected v=%b rdy=%b", cyc,
                                   o_valid, o_ready, q.size() != 0, q.size() < 2);
            end
            if (q.size() != 0) begin
                n_checks++;
                if (observed() !== q[0]) begin
                    n_fail++; $display("FAIL rnd_head cyc %0d: got %h expected %h", cyc, observed(), q[0]);
                end
            end else begin
                n_checks++;
                if (o_pc !== TAG) begin
                    n_fail++; $display("FAIL rnd_empty_pc cyc %0d: got %h expected %h", cyc, o_pc, TAG);
                end
            end
            acc = i_valid && (q.size() < 2);
            pop = i_ready && (q.size() != 0);
            tick();
            if (i_flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(model_dec(i_inst, i_pc));
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_csr();
        test_illegal_zero();
        test_reset_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
